id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the EXE block and its ALU. It registers decoded operands and control from the decode stage and generates the 4-bit `ALU_operation` code from ALUOp/funct. It forwards results from the EX/MEM and MEM/WB stages onto the `A`/`B` operand buses, and detects load-use hazards, inserting one bubble per hazard. Its outputs drive `A`, `B` and `ALU_operation` of EXE directly.

## Interface
Parameters:
- `W`, 32, datapath width
- `RW`, 5, register-index width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `stall`  in  1  downstream hold; ID/EX contents frozen
- `flush`  in  1  replace ID/EX contents with a bubble (branch taken)
- `id_valid`  in  1  decode stage presents a valid instruction
- `id_rs_data`, `id_rt_data`, `id_imm`  in  W  register-file operands, sign-extended immediate
- `id_rs`, `id_rt`, `id_rd`  in  RW  source and destination indices
- `id_alu_op`  in  2  00 add, 01 sub, 10 R-type (use funct), 11 reserved→add
- `id_funct`  in  6  R-type funct field
- `id_alu_src`, `id_reg_dst`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`  in  1  decoded control
- `exmem_reg_write`  in  1, `exmem_rd`  in  RW, `exmem_result`  in  W  EX/MEM producer
- `memwb_reg_write`  in  1, `memwb_rd`  in  RW, `memwb_result`  in  W  MEM/WB producer
- `hazard_stall`  out  1  combinational; tells IF/ID to hold
- `ex_valid`  out  1  EX stage holds a real instruction
- `A`, `B`  out  W  ALU operands
- `ALU_operation`  out  4  ALU code
- `ex_store_data`  out  W  forwarded rt value for stores
- `ex_dest`  out  RW  write-back index (rd if reg_dst, else rt)
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`  out  1  registered control
- `illegal_funct`  out  1  registered; R-type funct not decoded

## Operation
- Register update priority, evaluated at each rising edge:
  1. `!rst_n`
  2. `flush`
  3. `stall` (hold)
  4. `hazard_stall` (load bubble)
  5. load from ID
- Bubble and reset state:
  - `ex_valid` is 0 and all control bits are 0, so a bubble never writes or accesses memory.
  - Data fields are 0.
  - The registered ALU code is 0010 (add).
- ALU code decode:
  - `id_alu_op` 00→0010, 01→0110.
  - `id_alu_op` 10 with funct 0x20→0010, 0x22→0110, 0x24→0000, 0x25→0001, 0x2A→0111.
  - Any other funct→0010, and `illegal_funct`=1 is registered with the instruction.
- Forwarding applies to rs→`A` and rt→store data/`B`, combinationally from the registered indices:
  - If `exmem_reg_write`, `exmem_rd`≠0 and it matches the source index, use `exmem_result`.
  - Otherwise, if the same conditions hold for the MEM/WB producer, use `memwb_result`.
  - Otherwise use the registered register-file value.
  - When both producers match, EX/MEM wins.
- Register 0 is never forwarded.
- `B` is the registered `id_imm` when `alu_src` is set; otherwise it is the forwarded rt value.
- Load-use hazard: `hazard_stall` = `ex_valid` & `ex_mem_read` & `ex_dest`≠0 & (`ex_dest`==`id_rs` | (`ex_dest`==`id_rt` & !`id_alu_src`)) & `id_valid`.
- `id_valid`=0 loads a bubble.

## Timing
- ID→EX latency is 1 cycle. Forwarding and `hazard_stall` are combinational, with no added cycle.
- A load-use hazard costs exactly 1 bubble. On the next cycle the load is in MEM and is forwarded from MEM/WB.
- `stall` together with `hazard_stall`: hold, no bubble. The hazard is re-evaluated after release.
- `flush` together with `stall`: flush wins.
- Reset mid-operation: the next edge gives the bubble state. `hazard_stall` drops because `ex_valid`=0.

## Configuration
- `ID_EX_FORWARDING_EN` defined: forwarding muxes and the load-use rule apply as above.
- Undefined:
  - `A`/store data are the registered register-file values.
  - `hazard_stall` additionally asserts on any RAW hazard (index ≠0) against `ex_dest` with `ex_reg_write`, or against `exmem_rd` with `exmem_reg_write`.
  - A bubble is inserted for each stalled cycle.

## Structure
- Shared package `cpu_pkg`:
  - ALU code constants `ALU_AND`=0000, `ALU_OR`=0001, `ALU_ADD`=0010, `ALU_SUB`=0110, `ALU_SLT`=0111.
  - Funct constants.
  - The ALUOp encoding.
  - A packed ID/EX control struct.
- One sub-module, `alu_control`: the combinational ALUOp/funct→`ALU_operation` decoder, reused by other stages.
- The forwarding muxes and pipeline register stay in `id_ex_stage`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles → `ex_valid`=0, control=0, `ALU_operation`=0010.
- R-type sub: `id_alu_op`=10, funct 0x22, rs_data=9, rt_data=4 → next cycle `ALU_operation`=0110, `A`=9, `B`=4.
- EX/MEM forward: `exmem_rd`=5, `exmem_result`=0xDEAD, registered rs=5 → `A`=0xDEAD. With `memwb_rd`=5 also matching, EX/MEM still wins. With `exmem_rd`=0 and rs=0 → raw value.
- Load-use: `lw` to r8 in EX, `add` reading r8 in ID → `hazard_stall`=1 for one cycle and a bubble enters EX. Next cycle `A`=`memwb_result`.
- Flush plus stall in the same cycle → bubble loaded; `ex_mem_write`=0.
- Illegal funct 0x3F → `ALU_operation`=0010, `illegal_funct`=1 on the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU codes, funct fields, ALUOp encoding
// and the ID/EX control bundle.
package cpu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic       valid;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       illegal;
    logic [3:0] alu_code;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = '{
    valid:      1'b0,
    alu_src:    1'b0,
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    illegal:    1'b0,
    alu_code:   ALU_ADD
  };

endpackage

// File: rtl/alu_control.sv
// ALUOp/funct to 4-bit ALU operation decoder.
// Unknown R-type funct falls back to add and raises illegal.
module alu_control
  import cpu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_code,
  output logic       illegal
);

  always_comb begin
    alu_code = ALU_ADD;
    illegal  = 1'b0;
    unique case (1'b1)
      alu_op == ALUOP_SUB: alu_code = ALU_SUB;
      alu_op == ALUOP_RTYPE: begin
        unique case (funct)
          FUNCT_ADD: alu_code = ALU_ADD;
          FUNCT_SUB: alu_code = ALU_SUB;
          FUNCT_AND: alu_code = ALU_AND;
          FUNCT_OR:  alu_code = ALU_OR;
          FUNCT_SLT: alu_code = ALU_SLT;
          default:   illegal  = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU decode and load-use detection.
// ID_EX_FORWARDING_EN enables EX/MEM and MEM/WB operand forwarding.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [W-1:0]  id_rs_data,
  input  logic [W-1:0]  id_rt_data,
  input  logic [W-1:0]  id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [1:0]    id_alu_op,
  input  logic [5:0]    id_funct,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [W-1:0]  exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [W-1:0]  memwb_result,
  output logic          hazard_stall,
  output logic          ex_valid,
  output logic [W-1:0]  A,
  output logic [W-1:0]  B,
  output logic [3:0]    ALU_operation,
  output logic [W-1:0]  ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          illegal_funct
);

  id_ex_ctrl_t   ctrl_q;
  id_ex_ctrl_t   ctrl_d;
  logic [W-1:0]  rs_data_q;
  logic [W-1:0]  rt_data_q;
  logic [W-1:0]  imm_q;
  logic [RW-1:0] rs_q;
  logic [RW-1:0] rt_q;
  logic [RW-1:0] dest_q;
  logic [3:0]    dec_code;
  logic          dec_illegal;
  logic [W-1:0]  rs_fwd;
  logic [W-1:0]  rt_fwd;
  logic          rs_hit_ex;
  logic          rt_hit_ex;
  logic          load_use;

  function automatic logic hit(
    input logic          we,
    input logic [RW-1:0] rd,
    input logic [RW-1:0] idx
  );
    return we && (rd != '0) && (rd == idx);
  endfunction

  alu_control u_alu_control (
    .alu_op   (id_alu_op),
    .funct    (id_funct),
    .alu_code (dec_code),
    .illegal  (dec_illegal)
  );

  always_comb begin
    ctrl_d = '{
      valid:      1'b1,
      alu_src:    id_alu_src,
      reg_write:  id_reg_write,
      mem_read:   id_mem_read,
      mem_write:  id_mem_write,
      mem_to_reg: id_mem_to_reg,
      illegal:    dec_illegal,
      alu_code:   dec_code
    };
  end

  assign rs_hit_ex = hit(1'b1, dest_q, id_rs);
  assign rt_hit_ex = hit(1'b1, dest_q, id_rt);
  assign load_use  = ctrl_q.valid & ctrl_q.mem_read
                   & (rs_hit_ex | (rt_hit_ex & ~id_alu_src));

`ifdef ID_EX_FORWARDING_EN
  // EX/MEM is the younger producer, so it is checked first.
  always_comb begin
    if (hit(exmem_reg_write, exmem_rd, rs_q))
      rs_fwd = exmem_result;
    else if (hit(memwb_reg_write, memwb_rd, rs_q))
      rs_fwd = memwb_result;
    else
      rs_fwd = rs_data_q;
  end

  always_comb begin
    if (hit(exmem_reg_write, exmem_rd, rt_q))
      rt_fwd = exmem_result;
    else if (hit(memwb_reg_write, memwb_rd, rt_q))
      rt_fwd = memwb_result;
    else
      rt_fwd = rt_data_q;
  end

  assign hazard_stall = id_valid & load_use;
`else
  logic ex_raw;
  logic mem_raw;
  logic unused_fwd;

  assign rs_fwd = rs_data_q;
  assign rt_fwd = rt_data_q;

  // Without bypass paths every in-flight producer must drain first.
  assign ex_raw  = ctrl_q.valid & ctrl_q.reg_write
                 & (rs_hit_ex | rt_hit_ex);
  assign mem_raw = hit(exmem_reg_write, exmem_rd, id_rs)
                 | hit(exmem_reg_write, exmem_rd, id_rt);

  assign hazard_stall = id_valid & (load_use | ex_raw | mem_raw);

  assign unused_fwd = ^{exmem_result, memwb_reg_write,
                        memwb_rd, memwb_result, rs_q, rt_q};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      ctrl_q    <= CTRL_BUBBLE;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      dest_q    <= '0;
    end else if (!stall) begin
      if (hazard_stall || !id_valid) begin
        ctrl_q    <= CTRL_BUBBLE;
        rs_data_q <= '0;
        rt_data_q <= '0;
        imm_q     <= '0;
        rs_q      <= '0;
        rt_q      <= '0;
        dest_q    <= '0;
      end else begin
        ctrl_q    <= ctrl_d;
        rs_data_q <= id_rs_data;
        rt_data_q <= id_rt_data;
        imm_q     <= id_imm;
        rs_q      <= id_rs;
        rt_q      <= id_rt;
        dest_q    <= id_reg_dst ? id_rd : id_rt;
      end
    end
  end

  assign ex_valid      = ctrl_q.valid;
  assign A             = rs_fwd;
  assign B             = ctrl_q.alu_src ? imm_q : rt_fwd;
  assign ALU_operation = ctrl_q.alu_code;
  assign ex_store_data = rt_fwd;
  assign ex_dest       = dest_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign illegal_funct = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues expected
// values per cycle, a negedge monitor pops and compares them.
module tb_id_ex_stage;

  localparam int W  = 32;
  localparam int RW = 5;

  localparam int S_VALID = 0;
  localparam int S_A     = 1;
  localparam int S_B     = 2;
  localparam int S_OP    = 3;
  localparam int S_HAZ   = 4;
  localparam int S_MEMW  = 5;
  localparam int S_ILL   = 6;
  localparam int S_CTRL  = 7;
  localparam int S_DEST  = 8;
  localparam int S_STORE = 9;

  // {alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg}
  localparam logic [5:0] R_CTL  = 6'b011000;
  localparam logic [5:0] LW_CTL = 6'b101101;
  localparam logic [5:0] ST_CTL = 6'b100010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          flush;
  logic          id_valid;
  logic [W-1:0]  id_rs_data;
  logic [W-1:0]  id_rt_data;
  logic [W-1:0]  id_imm;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic [1:0]    id_alu_op;
  logic [5:0]    id_funct;
  logic          id_alu_src;
  logic          id_reg_dst;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_mem_to_reg;
  logic          exmem_reg_write;
  logic [RW-1:0] exmem_rd;
  logic [W-1:0]  exmem_result;
  logic          memwb_reg_write;
  logic [RW-1:0] memwb_rd;
  logic [W-1:0]  memwb_result;
  logic          hazard_stall;
  logic          ex_valid;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [3:0]    ALU_operation;
  logic [W-1:0]  ex_store_data;
  logic [RW-1:0] ex_dest;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_mem_to_reg;
  logic          illegal_funct;

  id_ex_stage #(.W(W), .RW(RW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_alu_op       (id_alu_op),
    .id_funct        (id_funct),
    .id_alu_src      (id_alu_src),
    .id_reg_dst      (id_reg_dst),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_mem_write    (id_mem_write),
    .id_mem_to_reg   (id_mem_to_reg),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .hazard_stall    (hazard_stall),
    .ex_valid        (ex_valid),
    .A               (A),
    .B               (B),
    .ALU_operation   (ALU_operation),
    .ex_store_data   (ex_store_data),
    .ex_dest         (ex_dest),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .illegal_funct   (illegal_funct)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  int          sb_cyc[$];
  int          sb_sel[$];
  logic [31:0] sb_exp[$];
  string       sb_name[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get(input int sel);
    case (sel)
      S_VALID: return {31'b0, ex_valid};
      S_A:     return A;
      S_B:     return B;
      S_OP:    return {28'b0, ALU_operation};
      S_HAZ:   return {31'b0, hazard_stall};
      S_MEMW:  return {31'b0, ex_mem_write};
      S_ILL:   return {31'b0, illegal_funct};
      S_CTRL:  return {28'b0, ex_reg_write, ex_mem_read,
                       ex_mem_write, ex_mem_to_reg};
      S_DEST:  return {27'b0, ex_dest};
      S_STORE: return ex_store_data;
      default: return 32'b0;
    endcase
  endfunction

  task automatic chk(input int off, input int sel,
                     input logic [31:0] exp, input string name);
    sb_cyc.push_back(cyc + off);
    sb_sel.push_back(sel);
    sb_exp.push_back(exp);
    sb_name.push_back(name);
  endtask

  always @(negedge clk) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sb_cyc.size()) begin
      if (sb_cyc[i] <= cyc) begin
        checks++;
        act = get(sb_sel[i]);
        if (sb_cyc[i] < cyc) begin
          errors++;
          $display("FAIL %s: expired, cycle %0d", sb_name[i], sb_cyc[i]);
        end else if (act !== sb_exp[i]) begin
          errors++;
          $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                   sb_name[i], act, sb_exp[i], cyc);
        end
        sb_cyc.delete(i);
        sb_sel.delete(i);
        sb_exp.delete(i);
        sb_name.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id;
    id_valid      = 1'b0;
    id_rs_data    = '0;
    id_rt_data    = '0;
    id_imm        = '0;
    id_rs         = '0;
    id_rt         = '0;
    id_rd         = '0;
    id_alu_op     = 2'b00;
    id_funct      = 6'h00;
    id_alu_src    = 1'b0;
    id_reg_dst    = 1'b0;
    id_reg_write  = 1'b0;
    id_mem_read   = 1'b0;
    id_mem_write  = 1'b0;
    id_mem_to_reg = 1'b0;
  endtask

  task automatic set_id(input logic [1:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [31:0] imm,
                        input logic [5:0] ctl);
    id_valid   = 1'b1;
    id_alu_op  = op;
    id_funct   = fn;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_rs_data = rsd;
    id_rt_data = rtd;
    id_imm     = imm;
    {id_alu_src, id_reg_dst, id_reg_write,
     id_mem_read, id_mem_write, id_mem_to_reg} = ctl;
  endtask

  initial begin
    clear_id();
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    exmem_reg_write = 1'b0;
    exmem_rd = '0;
    exmem_result = '0;
    memwb_reg_write = 1'b0;
    memwb_rd = '0;
    memwb_result = '0;

    tick();
    tick();
    // cycle 2: reset state, then R-type sub
    rst_n = 1'b1;
    chk(0, S_VALID, 0, "rst_valid");
    chk(0, S_CTRL, 0, "rst_ctrl");
    chk(0, S_OP, 4'b0010, "rst_op");
    chk(0, S_ILL, 0, "rst_illegal");
    chk(0, S_HAZ, 0, "rst_hazard");
    set_id(2'b10, 6'h22, 5'd1, 5'd2, 5'd3, 32'd9, 32'd4, 32'd0, R_CTL);
    chk(1, S_VALID, 1, "sub_valid");
    chk(1, S_OP, 4'b0110, "sub_op");
    chk(1, S_A, 9, "sub_a");
    chk(1, S_B, 4, "sub_b");
    chk(1, S_DEST, 3, "sub_dest");
    chk(1, S_CTRL, 4'b1000, "sub_ctrl");

    tick();
    set_id(2'b00, 6'h00, 5'd5, 5'd6, 5'd0,
           32'h1111, 32'h2222, 32'd0, 6'b000000);
    chk(0, S_HAZ, 0, "i2_hazard");

    tick();
    set_id(2'b00, 6'h00, 5'd0, 5'd7, 5'd0,
           32'h0ABC, 32'h77, 32'd0, 6'b000000);
    exmem_reg_write = 1'b1;
    exmem_rd = 5'd5;
    exmem_result = 32'hDEAD;
    memwb_reg_write = 1'b1;
    memwb_rd = 5'd5;
    memwb_result = 32'hBEEF;
`ifdef ID_EX_FORWARDING_EN
    chk(0, S_A, 32'hDEAD, "fwd_exmem_wins_a");
`else
    chk(0, S_A, 32'h1111, "nofwd_raw_a");
`endif
    chk(0, S_B, 32'h2222, "b_no_match");
    chk(0, S_HAZ, 0, "i3_hazard");

    tick();
    clear_id();
    exmem_rd = 5'd0;
    memwb_rd = 5'd7;
`ifdef ID_EX_FORWARDING_EN
    chk(0, S_B, 32'hBEEF, "fwd_memwb_b");
    chk(0, S_STORE, 32'hBEEF, "fwd_memwb_store");
`else
    chk(0, S_B, 32'h77, "nofwd_raw_b");
    chk(0, S_STORE, 32'h77, "nofwd_raw_store");
`endif
    chk(0, S_A, 32'h0ABC, "r0_not_forwarded");

    tick();
    exmem_reg_write = 1'b0;
    memwb_reg_write = 1'b0;
    memwb_rd = 5'd0;
    set_id(2'b00, 6'h00, 5'd1, 5'd8, 5'd0,
           32'h100, 32'd0, 32'd4, LW_CTL);
    chk(0, S_HAZ, 0, "lw_hazard");
    chk(1, S_CTRL, 4'b1101, "lw_ctrl");
    chk(1, S_DEST, 8, "lw_dest");
    chk(1, S_A, 32'h100, "lw_a");
    chk(1, S_B, 4, "lw_b_imm");

    tick();
    set_id(2'b10, 6'h20, 5'd8, 5'd9, 5'd10,
           32'd5, 32'h30, 32'd0, R_CTL);
    chk(0, S_HAZ, 1, "load_use_hazard");
    chk(1, S_VALID, 0, "load_use_bubble");
    chk(1, S_CTRL, 0, "load_use_bubble_ctrl");

    tick();
    exmem_reg_write = 1'b1;
    exmem_rd = 5'd8;
    exmem_result = 32'h0104;
`ifdef ID_EX_FORWARDING_EN
    chk(0, S_HAZ, 0, "load_use_release");
`else
    chk(0, S_HAZ, 1, "raw_exmem_hazard");
`endif

    tick();
    exmem_reg_write = 1'b0;
    exmem_rd = 5'd0;
    memwb_reg_write = 1'b1;
    memwb_rd = 5'd8;
    memwb_result = 32'hCAFE;
`ifdef ID_EX_FORWARDING_EN
    clear_id();
    chk(0, S_A, 32'hCAFE, "load_fwd_memwb_a");
    chk(0, S_B, 32'h30, "load_fwd_b");
    chk(0, S_VALID, 1, "add_valid");
    chk(0, S_OP, 4'b0010, "add_op");
`else
    id_rs_data = 32'hCAFE;
    chk(0, S_HAZ, 0, "raw_release");
    chk(1, S_A, 32'hCAFE, "add_a");
    chk(1, S_B, 32'h30, "add_b");
    chk(1, S_VALID, 1, "add_valid");
    chk(1, S_OP, 4'b0010, "add_op");
`endif

    tick();
    memwb_reg_write = 1'b0;
    memwb_rd = 5'd0;
    set_id(2'b00, 6'h00, 5'd0, 5'd0, 5'd0,
           32'd0, 32'd0, 32'd0, ST_CTL);
    stall = 1'b1;
    flush = 1'b1;
    chk(1, S_VALID, 0, "flush_stall_valid");
    chk(1, S_MEMW, 0, "flush_stall_memw");

    tick();
    stall = 1'b0;
    flush = 1'b0;
    set_id(2'b00, 6'h00, 5'd1, 5'd8, 5'd0,
           32'h100, 32'd0, 32'd4, LW_CTL);

    tick();
    set_id(2'b10, 6'h20, 5'd8, 5'd9, 5'd10,
           32'd5, 32'h30, 32'd0, R_CTL);
    stall = 1'b1;
    chk(0, S_HAZ, 1, "stall_hazard");
    chk(1, S_VALID, 1, "stall_hold_valid");
    chk(1, S_DEST, 8, "stall_hold_dest");
    chk(1, S_CTRL, 4'b1101, "stall_hold_ctrl");

    tick();
    stall = 1'b0;
    chk(0, S_HAZ, 1, "rehazard");
    chk(1, S_VALID, 0, "rehazard_bubble");

    tick();
    set_id(2'b10, 6'h3F, 5'd0, 5'd0, 5'd0,
           32'd0, 32'd0, 32'd0, 6'b000000);
    chk(1, S_OP, 4'b0010, "illegal_op");
    chk(1, S_ILL, 1, "illegal_flag");

    tick();
    id_funct = 6'h24;
    chk(1, S_OP, 4'b0000, "and_op");
    chk(1, S_ILL, 0, "and_legal");

    tick();
    id_funct = 6'h25;
    chk(1, S_OP, 4'b0001, "or_op");

    tick();
    id_funct = 6'h2A;
    chk(1, S_OP, 4'b0111, "slt_op");

    tick();
    id_alu_op = 2'b11;
    id_funct = 6'h22;
    chk(1, S_OP, 4'b0010, "rsvd_op");
    chk(1, S_ILL, 0, "rsvd_legal");

    tick();
    id_alu_op = 2'b01;
    chk(1, S_OP, 4'b0110, "aluop_sub");

    tick();
    set_id(2'b00, 6'h00, 5'd1, 5'd8, 5'd0,
           32'h100, 32'd0, 32'd4, LW_CTL);

    tick();
    set_id(2'b10, 6'h20, 5'd8, 5'd9, 5'd10,
           32'd5, 32'h30, 32'd0, R_CTL);
    rst_n = 1'b0;
    chk(0, S_HAZ, 1, "pre_reset_hazard");
    chk(1, S_VALID, 0, "mid_reset_valid");
    chk(1, S_CTRL, 0, "mid_reset_ctrl");
    chk(1, S_OP, 4'b0010, "mid_reset_op");

    tick();
    rst_n = 1'b1;
    chk(0, S_HAZ, 0, "post_reset_hazard");
    chk(1, S_A, 5, "post_reset_a");

    tick();
    clear_id();
    tick();
    tick();

    checks++;
    if (sb_cyc.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0",
               sb_cyc.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
